// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared constants, FSM state encoding and a helper for the mux_arb_8
// round-robin arbiter and its rotating picker.
// Optional feature macro used by the top: MUX_ARB_HOLD_LIMIT_EN.
package mux_arb_pkg;

   localparam int N_REQ      = 8;
   localparam int SEL_W      = 3;
   localparam int HOLD_CNT_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // One-hot vector with only bit idx set.
   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux_arb_8_rr_pick8.sv
// rr_pick8
// Combinational rotating first-set search over 8 requests.
// Ports:
//   req_i   [7:0]  request vector
//   ptr_i   [2:0]  index with highest priority
//   excl_i  [7:0]  requests to ignore (the current owner on handover)
//   found_o        at least one eligible request
//   idx_o   [2:0]  first eligible index scanning ptr, ptr+1, ... mod 8
module rr_pick8
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] ptr_i,
   input  logic [N_REQ-1:0] excl_i,
   output logic             found_o,
   output logic [SEL_W-1:0] idx_o
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         // 3-bit addition wraps 7 -> 0 on its own
         cand = ptr_i + SEL_W'(k);
         if (!found_o && req_i[cand] && !excl_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_arb_8.sv
// mux_arb_8
// Round-robin arbiter sharing one 8:1 single-bit mux between 8 requesters.
// A grant is held while its owner keeps requesting; when the owner drops,
// the next pending requester takes over on the same edge.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   req    [7:0] level-sensitive requests
//   i      [7:0] data bit per requester
//   gnt    [7:0] registered one-hot grant, zero when idle
//   sel    [2:0] registered index of the granted requester
//   valid  registered, high while a grant is held
//   y      i[sel] while valid, else 0
// Optional: define MUX_ARB_HOLD_LIMIT_EN to force rotation after HOLD_MAX
// consecutive grant cycles when another requester is waiting.
module mux_arb_8
   import mux_arb_pkg::*;
#(
   parameter int N        = 8,
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     i,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] sel,
   output logic             valid,
   output logic             y
);

   state_e           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic [N-1:0]     excl;
   logic             found;
   logic [SEL_W-1:0] idx;
   logic             force_rot;
   logic             load;
   logic             keep;

   // While granting, the owner is masked so the search yields the next
   // requester after it (ptr already sits at owner+1).
   assign excl = (state_q == ST_GRANT) ? onehot(sel_q) : '0;

   rr_pick8 u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .excl_i  (excl),
      .found_o (found),
      .idx_o   (idx)
   );

`ifdef MUX_ARB_HOLD_LIMIT_EN
   logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

   // Rotation is only forced when someone else is actually waiting.
   assign force_rot = (cnt_q >= HOLD_CNT_W'(HOLD_MAX)) && found;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = HOLD_CNT_W'(1);
      end else if (keep && (cnt_q != '1)) begin
         cnt_d = cnt_q + HOLD_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign force_rot = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      load    = 1'b0;
      keep    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               load = 1'b1;
            end
         end
         ST_GRANT: begin
            if (req[sel_q] && !force_rot) begin
               keep = 1'b1;
            end else if (found) begin
               load = 1'b1;
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               sel_d   = '0;
               valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         state_d = ST_GRANT;
         gnt_d   = onehot(idx);
         sel_d   = idx;
         valid_d = 1'b1;
         // Last winner gets lowest priority next time
         ptr_d   = idx + SEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt   = gnt_q;
   assign sel   = sel_q;
   assign valid = valid_q;
   assign y     = valid_q ? i[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux_arb_8.sv
module tb_mux_arb_8;

`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam int HM = 4;
`else
   localparam int HM = 16;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] i;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       valid;
   logic       y;

   int errors = 0;
   int checks = 0;

   mux_arb_8 #(.N(8), .HOLD_MAX(HM)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .i     (i),
      .gnt   (gnt),
      .sel   (sel),
      .valid (valid),
      .y     (y)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   initial begin
      logic [7:0] m;
      // 1. Reset with all requests pending
      rst = 1'b1; req = 8'hFF; i = 8'hFF;
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 32'h00);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_y", 32'(y), 32'h0);
      rst = 1'b0;
      tick();
      chk("first_gnt", 32'(gnt), 32'h01);
      chk("first_sel", 32'(sel), 32'h0);
      chk("first_valid", 32'(valid), 32'h1);
      tick();
      chk("hold_gnt", 32'(gnt), 32'h01);

      // 2. Each owner drops for one cycle: back-to-back handover 0->1->...->7->0
      for (int k = 0; k < 8; k++) begin
         m = 8'h01 << k;
         req = 8'hFF & ~m;
         tick();
         m = 8'h01 << ((k + 1) % 8);
         chk("rot_gnt", 32'(gnt), 32'(m));
         chk("rot_sel", 32'(sel), 32'((k + 1) % 8));
         chk("rot_valid", 32'(valid), 32'h1);
      end

      // 3. Wrap-around: owner 0 hands to 5 (ptr=6), then 0 wins over 2
      req = 8'h20;
      tick();
      chk("to5_gnt", 32'(gnt), 32'h20);
      req = 8'b0000_0101;
      tick();
      chk("wrap_gnt", 32'(gnt), 32'h01);
      chk("wrap_sel", 32'(sel), 32'h0);
      req = 8'h04;
      tick();
      chk("wrap_next_gnt", 32'(gnt), 32'h04);
      chk("wrap_next_sel", 32'(sel), 32'h2);

      // 4. Data path on index 5
      req = 8'h20;
      tick();
      chk("dp_sel", 32'(sel), 32'h5);
      i = 8'b0010_0000;
      #1;
      chk("dp_y1", 32'(y), 32'h1);
      i = 8'hDF;
      #1;
      chk("dp_y0", 32'(y), 32'h0);
      i = 8'hFF;
      req = 8'h00;
      tick();
      chk("idle_valid", 32'(valid), 32'h0);
      chk("idle_gnt", 32'(gnt), 32'h00);
      chk("idle_y", 32'(y), 32'h0);

      // 5. Reset mid-grant on index 3; ptr must return to 0
      req = 8'h08;
      tick();
      chk("g3_gnt", 32'(gnt), 32'h08);
      tick();
      chk("g3_hold", 32'(gnt), 32'h08);
      rst = 1'b1;
      tick();
      chk("midrst_gnt", 32'(gnt), 32'h00);
      chk("midrst_valid", 32'(valid), 32'h0);
      rst = 1'b0;
      req = 8'h18;
      tick();
      chk("postrst_gnt", 32'(gnt), 32'h08);
      chk("postrst_sel", 32'(sel), 32'h3);

      // 6. Hold behaviour: owner 2 keeps requesting while 6 waits
      req = 8'h00;
      tick();
      chk("idle2_valid", 32'(valid), 32'h0);
      req = 8'h04;
      tick();
      chk("hold_c1", 32'(gnt), 32'h04);
      req = 8'h44;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_keep", 32'(gnt), 32'h04);
      end
`ifdef MUX_ARB_HOLD_LIMIT_EN
      tick();
      chk("hold_force", 32'(gnt), 32'h40);
      chk("hold_force_sel", 32'(sel), 32'h6);
`else
      for (int k = 0; k < 17; k++) begin
         tick();
         chk("hold_nolimit", 32'(gnt), 32'h04);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
